// File: rtl/vi_pkg.sv
// Shared defaults for the integer register file and its scoreboard.
package vi_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/int_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations and raises RAW/WAW stalls.
module int_scoreboard
    import vi_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic [NUM_READ-1:0]        rd_en_i,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_READ-1:0]        rd_busy_o,
    input  logic                       issue_valid_i,
    input  logic [ADDR_W-1:0]          issue_addr_i,
    output logic                       stall_o,
    input  logic                       wr_enable_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic                       flush_i,
    output logic [ADDR_W:0]            pending_cnt_o
);

    localparam int                NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [NREG-1:0]     r_busy;
    logic [NREG-1:0]     w_busy_nxt;
    logic [ADDR_W:0]     r_pending;
    logic [ADDR_W:0]     w_pending_nxt;
    logic [NUM_READ-1:0] w_rd_busy;
    logic                w_issue_haz;
    logic                w_stall;
    logic                w_issue_fire;

    // A same-cycle write-back to the read address hides the busy bit.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        assign w_addr       = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign w_hit        = wr_enable_i && (wr_addr_i == w_addr) && (w_addr != ZERO);
        assign w_rd_busy[k] = r_busy[w_addr] & ~w_hit;
    end

    // WAW: the destination is still pending unless its write-back lands now.
    assign w_issue_haz  = issue_valid_i && (issue_addr_i != ZERO) && r_busy[issue_addr_i]
                          && !(wr_enable_i && (wr_addr_i == issue_addr_i));
    assign w_stall      = (|(rd_en_i & w_rd_busy)) | w_issue_haz;
    assign w_issue_fire = issue_valid_i && !w_stall && !flush_i && (issue_addr_i != ZERO);

    assign rd_busy_o     = w_rd_busy;
    assign stall_o       = w_stall;
    assign pending_cnt_o = r_pending;

    // Next busy vector: flush, then issue (beats write-back), then write-back clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r < NREG; r++) begin
            if (flush_i)
                w_busy_nxt[r] = 1'b0;
            else if (w_issue_fire && (issue_addr_i == ADDR_W'(r)))
                w_busy_nxt[r] = 1'b1;
            else if (wr_enable_i && (wr_addr_i == ADDR_W'(r)))
                w_busy_nxt[r] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Population count of the post-update busy vector, so the register tracks busy exactly.
    always_comb begin
        w_pending_nxt = '0;
        for (int r = 0; r < NREG; r++)
            w_pending_nxt = w_pending_nxt + (ADDR_W+1)'(w_busy_nxt[r]);
    end

    // Busy vector and pending count state.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= w_pending_nxt;
        end
    end

endmodule

// File: rtl/int_regfile_sb.sv
// Integer register file with N bypassed read ports and an in-flight scoreboard.
module int_regfile_sb
    import vi_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic [NUM_READ-1:0]        rd_en_i,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_READ*DATA_W-1:0] rd_data_o,
    output logic [NUM_READ-1:0]        rd_busy_o,
    input  logic                       issue_valid_i,
    input  logic [ADDR_W-1:0]          issue_addr_i,
    output logic                       stall_o,
    input  logic                       wr_enable_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       flush_i,
    output logic [ADDR_W:0]            pending_cnt_o
);

    localparam int                NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    if ((NUM_READ < 1) || (NUM_READ > 4)) begin : g_bad_num_read
        $error("int_regfile_sb: NUM_READ must be 1..4");
    end

    logic [NREG-1:0][DATA_W-1:0] r_regs;

    // Storage write; x0 is never written so it always reads zero.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i)
            r_regs <= '0;
        else if (wr_enable_i && (wr_addr_i != ZERO))
            r_regs[wr_addr_i] <= wr_data_i;
    end

    // Read muxes with same-cycle write-back bypass.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign w_hit  = wr_enable_i && (wr_addr_i == w_addr) && (w_addr != ZERO);
        assign rd_data_o[k*DATA_W +: DATA_W] = w_hit ? wr_data_i : r_regs[w_addr];
    end

    int_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ)
    ) u_sb (
        .clk_i         (clk_i),
        .rsn_i         (rsn_i),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_busy_o     (rd_busy_o),
        .issue_valid_i (issue_valid_i),
        .issue_addr_i  (issue_addr_i),
        .stall_o       (stall_o),
        .wr_enable_i   (wr_enable_i),
        .wr_addr_i     (wr_addr_i),
        .flush_i       (flush_i),
        .pending_cnt_o (pending_cnt_o)
    );

endmodule

// File: tb/tb_int_regfile_sb.sv
// Bench for int_regfile_sb: directed scenarios then random traffic vs. a reference model.
module tb_int_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NREG = 32;

    logic             clk = 1'b0;
    logic             rsn;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             issue_valid;
    logic [AW-1:0]    issue_addr;
    logic             stall;
    logic             wr_enable;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             flush;
    logic [AW:0]      pending_cnt;

    int_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) dut (
        .clk_i(clk), .rsn_i(rsn), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_busy_o(rd_busy), .issue_valid_i(issue_valid),
        .issue_addr_i(issue_addr), .stall_o(stall), .wr_enable_i(wr_enable),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .flush_i(flush),
        .pending_cnt_o(pending_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents plus set of pending destinations.
    logic [DW-1:0] m_reg [NREG];
    bit            m_busy [NREG];
    bit            e_stall;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    function automatic bit wb_hits(input int a);
        return wr_enable && (int'(wr_addr) == a) && (a != 0);
    endfunction

    function automatic int port_addr(input int k);
        logic [NR*AW-1:0] v;
        v = rd_addr;
        return int'(v[k*AW +: AW]);
    endfunction

    task automatic idle();
        rd_en = '0; rd_addr = '0; issue_valid = 0; issue_addr = '0;
        wr_enable = 0; wr_addr = '0; wr_data = '0; flush = 0;
    endtask

    task automatic set_rd(input int k, input int a, input bit en);
        rd_addr[k*AW +: AW] = AW'(a);
        rd_en[k] = en;
    endtask

    // Compare every combinational output against the model for the current inputs.
    task automatic check_comb();
        logic [NR*DW-1:0] d;
        d = rd_data;
        e_stall = 1'b0;
        for (int k = 0; k < NR; k++) begin
            int a;
            logic [DW-1:0] ed;
            bit eb;
            a  = port_addr(k);
            ed = wb_hits(a) ? wr_data : m_reg[a];
            eb = m_busy[a] && !wb_hits(a);
            chk($sformatf("rd_data[%0d] x%0d", k, a), 64'(d[k*DW +: DW]), 64'(ed));
            chk($sformatf("rd_busy[%0d] x%0d", k, a), 64'(rd_busy[k]), 64'(eb));
            if (rd_en[k] && eb) e_stall = 1'b1;
        end
        if (issue_valid && issue_addr != 0 && m_busy[issue_addr]
            && !(wr_enable && wr_addr == issue_addr))
            e_stall = 1'b1;
        chk("stall", 64'(stall), 64'(e_stall));
    endtask

    task automatic neg();
        @(negedge clk);
        check_comb();
    endtask

    // Clock edge: write-back retires first, an accepted issue then re-marks, flush wipes all.
    task automatic pos();
        bit fire;
        fire = issue_valid && !e_stall && !flush && issue_addr != 0;
        @(posedge clk);
        if (wr_enable && wr_addr != 0) begin
            m_reg[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (fire) m_busy[issue_addr] = 1'b1;
        if (flush) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        #1;
        chk("pending_cnt", 64'(pending_cnt), 64'(m_count()));
        idle();
    endtask

    initial begin
        rsn = 1'b0;
        idle();
        m_reset();
        #12;
        check_comb();
        chk("reset pending_cnt", 64'(pending_cnt), 64'd0);
        @(posedge clk); #1;
        rsn = 1'b1;

        // Write-back bypass then storage read.
        set_rd(0, 5, 1); wr_enable = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        neg(); chk("bypass x5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
        pos();
        set_rd(1, 5, 1);
        neg(); chk("storage x5", 64'(rd_data[2*DW-1:DW]), 64'hDEADBEEF);
        pos();

        // RAW stall on x3 released by its write-back.
        issue_valid = 1; issue_addr = 3;
        neg(); pos();
        set_rd(0, 3, 1);
        neg(); chk("raw stall", 64'(stall), 64'd1);
        chk("pending after issue", 64'(pending_cnt), 64'd1);
        pos();
        set_rd(0, 3, 1); wr_enable = 1; wr_addr = 3; wr_data = 32'h12;
        neg(); chk("raw release", 64'(stall), 64'd0);
        chk("wb data x3", 64'(rd_data[DW-1:0]), 64'h12);
        pos(); chk("pending after wb", 64'(pending_cnt), 64'd0);

        // WAW on x3.
        issue_valid = 1; issue_addr = 3;
        neg(); pos();
        issue_valid = 1; issue_addr = 3;
        neg(); chk("waw stall", 64'(stall), 64'd1);
        pos(); chk("waw pending", 64'(pending_cnt), 64'd1);
        issue_valid = 1; issue_addr = 3; wr_enable = 1; wr_addr = 3; wr_data = 32'h34;
        neg(); chk("waw with wb", 64'(stall), 64'd0);
        pos(); chk("waw busy kept", 64'(pending_cnt), 64'd1);
        set_rd(0, 3, 0);
        neg(); chk("x3 still busy", 64'(rd_busy[0]), 64'd1);
        chk("x3 new data", 64'(rd_data[DW-1:0]), 64'h34);
        pos();
        wr_enable = 1; wr_addr = 3; wr_data = 32'h35;
        neg(); pos();

        // Three issues then flush with write-back.
        issue_valid = 1; issue_addr = 1; neg(); pos();
        issue_valid = 1; issue_addr = 2; neg(); pos();
        issue_valid = 1; issue_addr = 4; neg(); pos();
        chk("three pending", 64'(pending_cnt), 64'd3);
        flush = 1; wr_enable = 1; wr_addr = 2; wr_data = 32'd7;
        neg(); pos();
        chk("flush pending", 64'(pending_cnt), 64'd0);
        set_rd(0, 1, 1); set_rd(1, 2, 1); set_rd(2, 4, 1); set_rd(3, 5, 1);
        neg(); chk("flush no busy", 64'(rd_busy), 64'd0);
        chk("x2 after flush", 64'(rd_data[2*DW-1:DW]), 64'd7);
        pos();

        // x0 ignores writes and issues.
        wr_enable = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        issue_valid = 1; issue_addr = 0;
        for (int k = 0; k < NR; k++) set_rd(k, 0, 1);
        neg(); chk("x0 no stall", 64'(stall), 64'd0);
        chk("x0 bypass blocked", 64'(rd_data[DW-1:0]), 64'd0);
        pos();
        set_rd(0, 0, 1); set_rd(1, 5, 1); set_rd(2, 2, 1); set_rd(3, 3, 1);
        issue_valid = 1; issue_addr = 0;
        neg(); chk("x0 reads 0", 64'(rd_data[DW-1:0]), 64'd0);
        chk("x0 never busy", 64'(pending_cnt), 64'd0);
        pos();

        // Asynchronous reset while x6 is busy holding 0x55.
        wr_enable = 1; wr_addr = 6; wr_data = 32'h55; neg(); pos();
        issue_valid = 1; issue_addr = 6; neg(); pos();
        set_rd(0, 6, 1);
        #2 rsn = 1'b0;
        #1;
        m_reset();
        chk("async rst data", 64'(rd_data[DW-1:0]), 64'd0);
        chk("async rst busy", 64'(rd_busy), 64'd0);
        chk("async rst stall", 64'(stall), 64'd0);
        chk("async rst pending", 64'(pending_cnt), 64'd0);
        @(posedge clk); #1;
        idle(); set_rd(0, 6, 1);
        #1; check_comb();
        rsn = 1'b1;

        // Random traffic on a small address window to provoke hazards.
        repeat (400) begin
            for (int k = 0; k < NR; k++) set_rd(k, int'($urandom_range(0, 7)), 1'($urandom));
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_addr  = AW'($urandom_range(0, 7));
            wr_enable   = ($urandom_range(0, 9) < 4);
            wr_addr     = AW'($urandom_range(0, 7));
            wr_data     = $urandom;
            flush       = ($urandom_range(0, 19) == 0);
            neg(); pos();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
